// File: rtl/magnitude_comparator_85_pkg.sv
// Shared types for the registered 74x85-style magnitude comparator.
//   cmp_flags_t     : packed {lt, eq, gt} result triple
//   FLAGS_CLEAR     : value the result register takes on reset
//   cascade_resolve : result for a == b, derived from the lower-order cascade
package magnitude_comparator_85_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_CLEAR = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

  // When the operands tie, the lower-order stage decides. Illegal cascade
  // combinations are not cleaned up: 000 yields lt=gt=1 and 101 yields all
  // zero, exactly as the 74x85 does, so chained parts behave identically.
  function automatic cmp_flags_t cascade_resolve(input logic ilt,
                                                 input logic ieq,
                                                 input logic igt);
    cmp_flags_t f;
    f.eq = ieq;
    f.gt = ~ieq & ~ilt;
    f.lt = ~ieq & ~igt;
    return f;
  endfunction

endpackage

// File: rtl/magnitude_comparator_85_core.sv
// Combinational core of the 74x85-style comparator.
//   a, b          : unsigned operands, WIDTH bits
//   ilt, ieq, igt : cascade inputs from the lower-order stage
//   nlt, neq, ngt : next-state compare result (not registered here)
module comparator_85_core
  import magnitude_comparator_85_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ilt,
  input  logic             ieq,
  input  logic             igt,
  output logic             nlt,
  output logic             neq,
  output logic             ngt
);

  cmp_flags_t flags;

  // A strict inequality on this stage dominates; cascade inputs only matter
  // on a tie.
  always_comb begin
    flags = FLAGS_CLEAR;
    if (a > b) begin
      flags.gt = 1'b1;
    end else if (a < b) begin
      flags.lt = 1'b1;
    end else begin
      flags = cascade_resolve(ilt, ieq, igt);
    end
  end

  assign nlt = flags.lt;
  assign neq = flags.eq;
  assign ngt = flags.gt;

endmodule

// File: rtl/magnitude_comparator_85.sv
// Registered magnitude comparator with 74x85 cascade semantics.
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset, clears all outputs
//   en            : capture enable; with en=0 the outputs hold
//   a, b          : unsigned operands, WIDTH bits
//   ilt, ieq, igt : cascade inputs (use 0,1,0 for a standalone compare)
//   olt, oeq, ogt : registered result, one cycle after capture
// There is no handshake: en is a plain load strobe, and a result is valid
// from the cycle after any non-reset cycle with en=1 until the next capture.
module magnitude_comparator_85
  import magnitude_comparator_85_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ilt,
  input  logic             ieq,
  input  logic             igt,
  output logic             olt,
  output logic             oeq,
  output logic             ogt
);

  cmp_flags_t core_flags;
  cmp_flags_t flags_d;
  cmp_flags_t flags_q;

  comparator_85_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .ilt(ilt),
    .ieq(ieq),
    .igt(igt),
    .nlt(core_flags.lt),
    .neq(core_flags.eq),
    .ngt(core_flags.gt)
  );

  always_comb begin
    flags_d = flags_q;
    if (en) begin
      flags_d = core_flags;
    end
  end

  // Reset takes priority over en, discarding any in-flight capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= FLAGS_CLEAR;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign olt = flags_q.lt;
  assign oeq = flags_q.eq;
  assign ogt = flags_q.gt;

endmodule

// File: tb/tb_magnitude_comparator_85.sv
module tb_magnitude_comparator_85;

  logic       clk = 1'b0;
  logic       rst, en, ilt, ieq, igt;
  logic [3:0] a, b;
  logic [7:0] a8, b8;
  logic       olt, oeq, ogt;
  logic       olt8, oeq8, ogt8;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp8_q[$];
  logic [2:0] last4 = 3'b000;
  logic [2:0] last8 = 3'b000;

  // clock / reset
  always #5 clk = ~clk;

  magnitude_comparator_85 #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .ilt(ilt), .ieq(ieq), .igt(igt),
    .olt(olt), .oeq(oeq), .ogt(ogt)
  );

  magnitude_comparator_85 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8),
    .ilt(ilt), .ieq(ieq), .igt(igt),
    .olt(olt8), .oeq(oeq8), .ogt(ogt8)
  );

  // Reference: {lt,eq,gt} from plain unsigned ordering plus the 74x85
  // tie table, listed row by row.
  function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y,
                                           input logic lt_i, input logic eq_i,
                                           input logic gt_i);
    logic [2:0] r;
    if (x > y) return 3'b001;
    if (x < y) return 3'b100;
    case ({lt_i, eq_i, gt_i})
      3'b001:  r = 3'b001;
      3'b100:  r = 3'b100;
      3'b101:  r = 3'b000;
      3'b000:  r = 3'b101;
      default: r = 3'b010;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got lt/eq/gt=%b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // model: expected register contents after each rising edge
  always @(posedge clk) begin
    logic [2:0] n4, n8;
    if (rst) begin
      n4 = 3'b000;
      n8 = 3'b000;
    end else if (en) begin
      n4 = ref_flags({4'b0, a}, {4'b0, b}, ilt, ieq, igt);
      n8 = ref_flags(a8, b8, ilt, ieq, igt);
    end else begin
      n4 = last4;
      n8 = last8;
    end
    last4 <= n4;
    last8 <= n8;
    exp_q.push_back(n4);
    exp8_q.push_back(n8);
  end

  // scoreboard compare, every cycle, on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("w4_cycle", {olt, oeq, ogt}, exp_q.pop_front());
    if (exp8_q.size() > 0) check("w8_cycle", {olt8, oeq8, ogt8}, exp8_q.pop_front());
  end

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] casc);
    a = av;
    b = bv;
    {ilt, ieq, igt} = casc;
  endtask

  initial begin
    logic [2:0] casc_tab[4];
    casc_tab = '{3'b000, 3'b100, 3'b010, 3'b001};

    rst = 1'b1; en = 1'b1;
    a8 = 8'h00; b8 = 8'h00;
    drive(4'd5, 4'd3, 3'b010);

    // pin the model with hand-computed rows
    check("model_gt",  ref_flags(8'd5, 8'd3, 1'b0, 1'b1, 1'b0), 3'b001);
    check("model_000", ref_flags(8'd3, 8'd3, 1'b0, 1'b0, 1'b0), 3'b101);
    check("model_101", ref_flags(8'd7, 8'd7, 1'b1, 1'b0, 1'b1), 3'b000);
    check("model_111", ref_flags(8'd7, 8'd7, 1'b1, 1'b1, 1'b1), 3'b010);
    check("model_uns", ref_flags(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0), 3'b001);

    // reset overrides en
    repeat (2) begin
      @(negedge clk);
      check("reset", {olt, oeq, ogt}, 3'b000);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", {olt, oeq, ogt}, 3'b001);

    // exhaustive WIDTH=4 sweep; the scoreboard checks each result
    for (int c = 0; c < 4; c++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          drive(ai[3:0], bi[3:0], casc_tab[c]);
          a8 = 8'($urandom_range(0, 255));
          b8 = 8'($urandom_range(0, 255));
          @(negedge clk);
        end
      end
    end

    // illegal cascade on a tie
    drive(4'd7, 4'd7, 3'b101);
    @(negedge clk);
    check("illegal_101", {olt, oeq, ogt}, 3'b000);
    drive(4'd7, 4'd7, 3'b111);
    @(negedge clk);
    check("illegal_111", {olt, oeq, ogt}, 3'b010);

    // enable hold
    drive(4'd2, 4'd9, 3'b010);
    @(negedge clk);
    check("hold_capture", {olt, oeq, ogt}, 3'b100);
    en = 1'b0;
    drive(4'd9, 4'd2, 3'b010);
    repeat (3) begin
      @(negedge clk);
      check("hold", {olt, oeq, ogt}, 3'b100);
    end
    en = 1'b1;
    @(negedge clk);
    check("hold_release", {olt, oeq, ogt}, 3'b001);

    // boundaries
    drive(4'd0, 4'd15, 3'b010);
    @(negedge clk);
    check("bound_0_15", {olt, oeq, ogt}, 3'b100);
    drive(4'd15, 4'd0, 3'b010);
    @(negedge clk);
    check("bound_15_0", {olt, oeq, ogt}, 3'b001);
    drive(4'd15, 4'd15, 3'b010);
    @(negedge clk);
    check("bound_15_15", {olt, oeq, ogt}, 3'b010);

    // WIDTH=8 unsigned ordering
    a8 = 8'h80; b8 = 8'h7F;
    @(negedge clk);
    check("w8_80_7f", {olt8, oeq8, ogt8}, 3'b001);
    a8 = 8'h7F; b8 = 8'h80;
    @(negedge clk);
    check("w8_7f_80", {olt8, oeq8, ogt8}, 3'b100);

    // randomized traffic with en gaps and occasional resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 24) == 0);
      en  = ($urandom_range(0, 3) != 0);
      a   = 4'($urandom_range(0, 15));
      b   = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      a8  = 8'($urandom_range(0, 255));
      b8  = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom_range(0, 255));
      {ilt, ieq, igt} = 3'($urandom_range(0, 7));
      @(negedge clk);
    end

    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
